// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage. Owns the program counter, drives the
//             word-addressed instruction port of the unified memory, and
//             captures the returned word into the IF/ID pipeline register.
//             Handles stall, flush, branch redirect, a halt opcode, and
//             keeps a saturating count of valid fetches.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             stall, flush        - hazard-unit hold / squash IF/ID
//             branch_taken,
//             branch_target       - PC redirect request and address
//             imem_addr           - instruction address (= PC, combinational)
//             imem_rdata          - instruction word from memory
//             if_instr, if_pc,
//             if_valid            - IF/ID pipeline register contents
//             halted              - high while the fetch FSM is halted
//             fetch_count         - saturating count of valid IF/ID loads
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                   WIDTH            = 32,
    parameter int                   INSTRUCTIONWIDTH = 16,
    parameter logic [WIDTH-1:0]     RESET_PC         = '0,
    parameter logic [3:0]           HALT_OPCODE      = 4'hF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        branch_taken,
    input  logic [WIDTH-1:0]            branch_target,
    output logic [WIDTH-1:0]            imem_addr,
    input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
    output logic [INSTRUCTIONWIDTH-1:0] if_instr,
    output logic [WIDTH-1:0]            if_pc,
    output logic                        if_valid,
    output logic                        halted,
    output logic [15:0]                 fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic [WIDTH-1:0]              r_pc;
    logic [INSTRUCTIONWIDTH-1:0]   r_if_instr;
    logic [WIDTH-1:0]              r_if_pc;
    logic                          r_if_valid;
    logic [15:0]                   r_fetch_count;
    logic                          w_load;
    logic                          w_is_halt;

    // A normal load happens only in RUN with no higher-priority event.
    assign w_load    = (r_state == ST_RUN) && !branch_taken && !stall && !flush;
    assign w_is_halt = (imem_rdata[INSTRUCTIONWIDTH-1 -: 4] == HALT_OPCODE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_BOOT:   w_next_state = ST_RUN;
            // Halt only when the halt word is actually loaded valid; an
            // older branch in the same cycle cancels it.
            ST_RUN:    if (w_load && w_is_halt) w_next_state = ST_HALTED;
            ST_HALTED: if (branch_taken)        w_next_state = ST_RUN;
            default:   w_next_state = ST_BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // PC and IF/ID datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken) begin
                        r_pc       <= branch_target;
                        r_if_valid <= 1'b0;
                    end else if (stall) begin
                        if (flush) begin
                            r_if_valid <= 1'b0;
                        end
                    end else if (flush) begin
                        // Word at PC is skipped, not refetched.
                        r_if_valid <= 1'b0;
                        r_pc       <= r_pc + WIDTH'(1);
                    end else begin
                        r_if_instr <= imem_rdata;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_pc       <= r_pc + WIDTH'(1);
                        if (r_fetch_count != 16'hFFFF) begin
                            r_fetch_count <= r_fetch_count + 16'd1;
                        end
                    end
                end
                ST_HALTED: begin
                    if (branch_taken) begin
                        r_pc       <= branch_target;
                        r_if_valid <= 1'b0;
                    end else if (flush) begin
                        r_if_valid <= 1'b0;
                    end
                end
                default: begin
                    // BOOT: PC holds at RESET_PC, redirects are ignored.
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_valid    = r_if_valid;
    assign halted      = (r_state == ST_HALTED);
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined processor, directly upstream of the decode stage. It owns the program counter and drives the instruction-port address of the unified `mem` block. It captures the 16-bit instruction word returned by `mem` into the IF/ID pipeline register. It handles stall, flush, branch redirect and a halt opcode, and keeps a saturating fetch counter for performance checks.

## Interface
- `WIDTH`, 32, address/PC width (matches `mem` address width)
- `INSTRUCTIONWIDTH`, 16, instruction word width (matches `mem` instruction port)
- `RESET_PC`, 0, PC value after reset
- `HALT_OPCODE`, 4'hF, value of instr[INSTRUCTIONWIDTH-1 -: 4] that halts fetch

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard unit: hold PC and IF/ID register
- `flush`  in  1  clear IF/ID valid (squash fetched instruction)
- `branch_taken`  in  1  redirect PC to `branch_target`
- `branch_target`  in  WIDTH  redirect address (word address)
- `imem_addr`  out  WIDTH  to `mem` a1; equals PC register (combinational)
- `imem_rdata`  in  INSTRUCTIONWIDTH  from `mem` rd1
- `if_instr`  out  INSTRUCTIONWIDTH  IF/ID instruction
- `if_pc`  out  WIDTH  IF/ID PC of `if_instr`
- `if_valid`  out  1  IF/ID entry valid
- `halted`  out  1  high while state = HALTED
- `fetch_count`  out  16  number of instructions loaded valid into IF/ID, saturating

## Operation
- The `mem` instruction port is word-addressed. `rd1` is combinational from `a1`. PC increments by 1 per fetched instruction.
- The PC wraps modulo 2^WIDTH. `fetch_count` saturates at 16'hFFFF.
- State machine with three states: BOOT, RUN, HALTED.
  - Reset puts the block in BOOT.
  - BOOT → RUN unconditionally after one cycle. No fetch occurs in BOOT, and the PC holds at RESET_PC.
  - RUN → HALTED when an instruction with opcode == HALT_OPCODE is loaded valid into IF/ID.
  - HALTED → RUN only on `branch_taken`. A halt fetched down a mispredicted path is cancelled by the older branch.
- Per-cycle update in RUN, first match wins:
  1. `branch_taken`: PC <= `branch_target`; `if_valid` <= 0. This applies regardless of `stall`.
  2. `stall`: PC, `if_instr`, `if_pc` and `if_valid` hold. If `flush` is also high, `if_valid` <= 0.
  3. `flush`: `if_valid` <= 0; PC <= PC+1; the instruction at PC is discarded.
  4. Otherwise: `if_instr` <= `imem_rdata`, `if_pc` <= PC, `if_valid` <= 1, PC <= PC+1, and `fetch_count` increments.
- In HALTED:
  - The PC is frozen at the address after the halt instruction.
  - The IF/ID register holds the halt instruction until it is flushed or overwritten. `flush` clears `if_valid`.
  - No new loads occur, and `fetch_count` is frozen.
- Reset values:
  - PC = RESET_PC
  - `if_instr` = 0, `if_pc` = 0, `if_valid` = 0
  - `fetch_count` = 0
  - `halted` = 0
  - state = BOOT
- When `rst_n` is asserted mid-operation, all of the above take effect immediately (asynchronously), and any in-flight redirect is lost.

## Timing
- Fetch latency: instruction at PC = A appears on `if_instr` with `if_valid` = 1 on the edge that samples PC = A, i.e. one cycle after `imem_addr` = A.
- First valid instruction: `imem_addr` = RESET_PC during BOOT and the first RUN cycle. `if_valid` rises at the end of the first RUN cycle, which is the second rising edge after reset release.
- Branch penalty: the cycle with `branch_taken` produces a bubble. `imem_addr` = `branch_target` on the next cycle, and the target instruction is valid one cycle later.
- `halted` rises on the same edge that loads the halt instruction.
- Simultaneous events:
  - `branch_taken` together with a halt-opcode fetch: the branch wins and no halt occurs.
  - `stall` with `branch_taken`: the redirect proceeds.
- `branch_taken` during BOOT is ignored.

## Test plan
- Reset release, memory at words 0..3 = 16'h1001, 16'h1002, 16'h1003, 16'h1004, no control inputs. Required response:
  - `if_valid` = 0 for the first edge.
  - Then `if_instr`/`if_pc` = 1001/0, 1002/1, 1003/2 on consecutive edges.
  - `fetch_count` = 3.
- Stall high for 2 cycles while `if_pc` = 1. Required response: `if_instr` stays 16'h1002 and `imem_addr` stays 2. After release, the next `if_pc` = 2 and no instruction is skipped.
- `branch_taken` = 1 with `branch_target` = 8 while PC = 3 (word 8 = 16'h2008). Required response: `if_valid` = 0 for one cycle, `imem_addr` = 8, then `if_instr` = 16'h2008 and `if_pc` = 8.
- Word 4 = 16'hF000. Required response: `halted` = 1 with `if_instr` = 16'hF000 and `imem_addr` frozen at 5. Then `branch_taken` with target 0 gives `halted` = 0 and a refetch of 16'h1001.
- `rst_n` pulsed low mid-stream with PC = 6. Required response: all outputs return to reset values immediately, without a clock edge. After release, fetch restarts at RESET_PC after one BOOT cycle.
- `branch_taken` in the same cycle as a halt-opcode fetch. Required response: `halted` stays 0 and the target instruction is fetched.
